branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised branch resolution and prediction unit, successor to the beq/bne zero-gating logic.
//  - Resolves beq, bne, blez, bgtz, bltz and bgez directly from register operands.
//  - Computes the branch target and registers the outcome (valid, taken, redirect PC, mispredict) one cycle later.
//  - Holds a 2-bit saturating-counter branch history table (BHT); the fetch stage reads it to predict, and resolved branches train it.
//  - Keeps saturating statistics counters for branches resolved and mispredicted.
// PARAMETERS
//  XLEN       32     datapath / PC width
//  BHT_DEPTH  16     BHT entries; power of 2, >=2; IDX_W = $clog2(BHT_DEPTH)
//  INIT_CTR   2'b01  value loaded into every BHT counter on reset (weakly not-taken)
//  CNT_W      16     width of each statistics counter
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  lookup_pc    in   XLEN    fetch-stage PC to predict
//  lookup_pred  out  1       prediction for lookup_pc; combinational; = BHT[idx(lookup_pc)][1]
//  valid_in     in   1       resolve request this cycle
//  flush_in     in   1       squash the request; overrides valid_in
//  opcode       in   6       instruction [31:26]
//  rt_field     in   5       instruction [20:16]; selects the REGIMM variant
//  rs_data      in   XLEN    rs operand
//  rt_data      in   XLEN    rt operand
//  imm_sext     in   XLEN    sign-extended 16-bit immediate
//  pc_in        in   XLEN    PC of the branch being resolved
//  pred_in      in   1       prediction that was made for this branch at fetch
//  res_valid    out  1       registered: a branch was resolved in the previous cycle
//  res_taken    out  1       registered: that branch was taken
//  redirect_pc  out  XLEN    registered: correct next PC for that branch
//  mispredict   out  1       registered: res_valid & (pred_in != taken)
//  br_count     out  CNT_W   number of branches resolved; saturating
//  mp_count     out  CNT_W   number of mispredictions; saturating
// BEHAVIOUR
//  - Branch decode; "acc" = valid_in & ~flush_in & is_branch. Comparisons are signed, against zero where noted:
//    - 000100 beq: taken = (rs == rt)
//    - 000101 bne: taken = (rs != rt)
//    - 000110 blez: taken = (rs <= 0)
//    - 000111 bgtz: taken = (rs > 0)
//    - 000001 with rt_field 00000 bltz: taken = (rs < 0)
//    - 000001 with rt_field 00001 bgez: taken = (rs >= 0)
//    - Any other opcode/rt_field: not a branch; no update, res_valid = 0.
//  - Arithmetic, all modulo 2^XLEN (wraps, no overflow flag):
//    - target = pc_in + 4 + (imm_sext << 2)
//    - redirect_pc = taken ? target : pc_in + 4
//  - BHT index: idx(pc) = pc[IDX_W+1:2].
//  - BHT update on acc only, at the clock edge:
//    - taken: counter increments, saturating at 3
//    - not taken: counter decrements, saturating at 0
//  - Same-index read and update in one cycle: lookup_pred returns the old (pre-update) value; the new value is visible next cycle.
//  - Output latency is exactly 1 cycle: res_* and mispredict are registered from the acc cycle.
//    - Cycles without acc drive res_valid = 0, res_taken = 0, mispredict = 0; redirect_pc holds its last value.
//  - Statistics:
//    - br_count += 1 on every acc.
//    - mp_count += 1 on acc with a mispredict.
//    - Both hold at all-ones once saturated.
//  - Reset (synchronous, highest priority; applies even mid-request, and that request is dropped):
//    - res_valid, res_taken, mispredict = 0; redirect_pc = 0.
//    - br_count, mp_count = 0.
//    - Every BHT entry = INIT_CTR, all in the single reset cycle.
//  - flush_in = 1 with valid_in = 1: no BHT change, no counter change, res_valid = 0 next cycle.
// TESTING
//  - Reset, then lookup_pc = 0x40 -> lookup_pred = 0; br_count = 0, mp_count = 0, res_valid = 0.
//  - beq, rs = rt = 5, pc_in = 0x100, imm = 3, pred_in = 0 -> next cycle: res_valid = 1, res_taken = 1, redirect_pc = 0x110, mispredict = 1, mp_count = 1.
//  - bgez / bltz / blez / bgtz with rs = 0x80000000 and rs = 0 -> taken values 0/1/1/0 and 1/0/1/0 respectively.
//  - Three taken beq at pc 0x20 -> counter goes 1->2->3->3; lookup_pred(0x20) = 1 after the first edge.
//  - pc_in = 0xFFFFFFFC, imm = 0 -> redirect_pc = 0x00000000 (wrap-around).
//  - Other cases:
//    - flush_in with valid_in -> no update and res_valid = 0.
//    - Reset asserted during a valid beq -> all outputs 0 and BHT = INIT_CTR.
//    - Drive 2^CNT_W + 2 branches with CNT_W = 4 -> br_count holds at 15.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Bus bundle for branch_resolve_unit: fetch-side prediction lookup, resolve request and registered outcome.
// Handshake: a request is taken whenever valid_in=1 and flush_in=0 on a rising edge (no back-pressure); the outcome appears with res_valid one cycle later.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  lookup_pc;
  logic             lookup_pred;
  logic             valid_in;
  logic             flush_in;
  logic [5:0]       opcode;
  logic [4:0]       rt_field;
  logic [XLEN-1:0]  rs_data;
  logic [XLEN-1:0]  rt_data;
  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  pc_in;
  logic             pred_in;
  logic             res_valid;
  logic             res_taken;
  logic [XLEN-1:0]  redirect_pc;
  logic             mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output lookup_pc, valid_in, flush_in, opcode, rt_field, rs_data, rt_data,
           imm_sext, pc_in, pred_in,
    input  lookup_pred, res_valid, res_taken, redirect_pc, mispredict,
           br_count, mp_count
  );

  modport slave (
    input  lookup_pc, valid_in, flush_in, opcode, rt_field, rs_data, rt_data,
           imm_sext, pc_in, pred_in,
    output lookup_pred, res_valid, res_taken, redirect_pc, mispredict,
           br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution (beq/bne/blez/bgtz/bltz/bgez), 2-bit saturating BHT for fetch prediction,
// and saturating resolved/mispredicted statistics; outcome is registered one cycle after the request.
module branch_resolve_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 16,
  parameter logic [1:0] INIT_CTR  = 2'b01,
  parameter int         CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  branch_resolve_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       r_bht [BHT_DEPTH];
  logic             r_res_valid;
  logic             r_res_taken;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_mispredict;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mp_count;

  logic             w_is_branch;
  logic             w_taken;
  logic             w_acc;
  logic             w_mispredict;
  logic             w_rs_zero;
  logic             w_rs_neg;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_lkp_idx;
  logic [1:0]       w_ctr;
  logic [XLEN-1:0]  w_seq_pc;
  logic [XLEN-1:0]  w_target;
  logic             w_unused_pc_bits;

  assign w_rs_zero = (bus.rs_data == '0);
  assign w_rs_neg  = bus.rs_data[XLEN-1];

  // Signed compares against zero reduce to the sign bit plus a zero test.
  always_comb begin
    w_is_branch = 1'b0;
    w_taken     = 1'b0;
    case (bus.opcode)
      6'b000100: begin w_is_branch = 1'b1; w_taken = (bus.rs_data == bus.rt_data); end
      6'b000101: begin w_is_branch = 1'b1; w_taken = (bus.rs_data != bus.rt_data); end
      6'b000110: begin w_is_branch = 1'b1; w_taken = w_rs_neg | w_rs_zero; end
      6'b000111: begin w_is_branch = 1'b1; w_taken = ~w_rs_neg & ~w_rs_zero; end
      6'b000001: begin
        if (bus.rt_field == 5'b00000) begin
          w_is_branch = 1'b1;
          w_taken     = w_rs_neg;
        end else if (bus.rt_field == 5'b00001) begin
          w_is_branch = 1'b1;
          w_taken     = ~w_rs_neg;
        end
      end
      default: ;
    endcase
  end

  assign w_acc        = bus.valid_in & ~bus.flush_in & w_is_branch;
  assign w_mispredict = bus.pred_in != w_taken;
  assign w_seq_pc     = bus.pc_in + XLEN'(4);
  assign w_target     = w_seq_pc + (bus.imm_sext << 2);

  assign w_upd_idx = bus.pc_in[IDX_W+1:2];
  assign w_lkp_idx = bus.lookup_pc[IDX_W+1:2];
  assign w_ctr     = r_bht[w_upd_idx];

  // Lookup reads the stored array, so a same-cycle update is only seen next cycle.
  assign bus.lookup_pred = r_bht[w_lkp_idx][1];

  assign w_unused_pc_bits = ^{bus.lookup_pc[XLEN-1:IDX_W+2], bus.lookup_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= INIT_CTR;
    end else if (w_acc) begin
      if (w_taken && w_ctr != 2'b11)       r_bht[w_upd_idx] <= w_ctr + 2'd1;
      else if (!w_taken && w_ctr != 2'b00) r_bht[w_upd_idx] <= w_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_br_count    <= '0;
      r_mp_count    <= '0;
    end else begin
      r_res_valid  <= w_acc;
      r_res_taken  <= w_acc & w_taken;
      r_mispredict <= w_acc & w_mispredict;
      if (w_acc) begin
        r_redirect_pc <= w_taken ? w_target : w_seq_pc;
        if (r_br_count != '1) r_br_count <= r_br_count + 1'b1;
        if (w_mispredict && r_mp_count != '1) r_mp_count <= r_mp_count + 1'b1;
      end
    end
  end

  assign bus.res_valid   = r_res_valid;
  assign bus.res_taken   = r_res_taken;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.mispredict  = r_mispredict;
  assign bus.br_count    = r_br_count;
  assign bus.mp_count    = r_mp_count;
endmodule
